// File: rtl/sys_array_out_deskew.sv
// sys_array_out_deskew: re-aligns skewed systolic-array result columns and buffers complete rows in a FIFO.
module sys_array_out_deskew #(
  parameter int MESHCOLS = 2,
  parameter int TILECOLS = 2,
  parameter int BITWIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic [MESHCOLS-1:0][TILECOLS-1:0][BITWIDTH-1:0] in_c,
  input  logic [MESHCOLS-1:0][TILECOLS-1:0]               in_c_valid,
  output logic [MESHCOLS-1:0][TILECOLS-1:0][BITWIDTH-1:0] out_row,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [$clog2(DEPTH+1)-1:0]                      count,
  output logic                                            overflow,
  output logic                                            align_err,
  input  logic                                            clear_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [TILECOLS-1:0][BITWIDTH-1:0] w_row [MESHCOLS];
  logic [TILECOLS-1:0]               w_vld [MESHCOLS];
  logic [MESHCOLS-1:0][TILECOLS-1:0][BITWIDTH-1:0] w_rowp;
  logic w_all, w_any, w_pop, w_push, w_ovf, w_bad;
  logic [MESHCOLS-1:0][TILECOLS-1:0][BITWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf, r_aerr;
  genvar l;
  generate
    for (l = 0; l < MESHCOLS; l++) begin : g_col
      localparam int S = MESHCOLS - 1 - l;
      if (S == 0) begin : g_pass
        assign w_row[l] = in_c[l];
        assign w_vld[l] = in_c_valid[l];
      end else begin : g_dly
        // column l waits S cycles for the last column to arrive
        logic [S-1:0][TILECOLS-1:0][BITWIDTH-1:0] r_d;
        logic [S-1:0][TILECOLS-1:0]               r_v;
        always_ff @(posedge clock) begin
          r_d[0] <= in_c[l];
          for (int s = 1; s < S; s++) r_d[s] <= r_d[s-1];
        end
        always_ff @(posedge clock) begin
          if (reset) r_v <= '0;
          else begin
            r_v[0] <= in_c_valid[l];
            for (int s = 1; s < S; s++) r_v[s] <= r_v[s-1];
          end
        end
        assign w_row[l] = r_d[S-1];
        assign w_vld[l] = r_v[S-1];
      end
    end
  endgenerate
  always_comb begin
    w_all = 1'b1;
    w_any = 1'b0;
    w_rowp = '0;
    for (int i = 0; i < MESHCOLS; i++) begin
      w_all = w_all & (&w_vld[i]);
      w_any = w_any | (|w_vld[i]);
      w_rowp[i] = w_row[i];
    end
  end
  assign w_pop  = out_valid & out_ready;
  assign w_push = w_all & ((r_cnt != CW'(DEPTH)) | w_pop);
  assign w_ovf  = w_all & (r_cnt == CW'(DEPTH)) & ~w_pop;
  assign w_bad  = w_any & ~w_all;
  always_ff @(posedge clock) if (w_push) r_mem[r_wp] <= w_rowp;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_aerr <= 1'b0;
    end else begin
      r_wp   <= w_push ? r_wp + AW'(1) : r_wp;
      r_rp   <= w_pop ? r_rp + AW'(1) : r_rp;
      r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_ovf  <= w_ovf | (r_ovf & ~clear_err);
      r_aerr <= w_bad | (r_aerr & ~clear_err);
    end
  end
  assign out_row   = r_mem[r_rp];
  assign out_valid = r_cnt != '0;
  assign count     = r_cnt;
  assign overflow  = r_ovf;
  assign align_err = r_aerr;
endmodule

// File: tb/tb_sys_array_out_deskew.sv
// tb_sys_array_out_deskew: directed checks of deskew alignment, FIFO ordering, overflow, alignment errors and reset.
module tb_sys_array_out_deskew;
  logic                  clock, reset, out_ready, clear_err;
  logic [1:0][1:0][7:0]  in_c;
  logic [1:0][1:0]       in_c_valid;
  logic [1:0][1:0][7:0]  out_row;
  logic                  out_valid, overflow, align_err;
  logic [2:0]            count;
  int n_cmp = 0;
  int n_err = 0;

  sys_array_out_deskew #(.MESHCOLS(2), .TILECOLS(2), .BITWIDTH(8), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .in_c(in_c), .in_c_valid(in_c_valid),
    .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .align_err(align_err), .clear_err(clear_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic [1:0] v1, input logic [7:0] a1, input logic [7:0] b1);
    in_c_valid[0] = v0;
    in_c[0][0] = a0;
    in_c[0][1] = b0;
    in_c_valid[1] = v1;
    in_c[1][0] = a1;
    in_c[1][1] = b1;
  endtask

  function automatic logic [31:0] row(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  task automatic idle;
    drive(2'b00, 8'd0, 8'd0, 2'b00, 8'd0, 8'd0);
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    clear_err = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_aerr", align_err, 0);

    // 1: single row
    out_ready = 1'b1;
    drive(2'b11, 8'd3, -8'sd4, 2'b00, 8'd0, 8'd0);
    tick();
    chk("t1_c1_valid", out_valid, 0);
    drive(2'b00, 8'd0, 8'd0, 2'b11, 8'd5, 8'd6);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_row", out_row, row(8'd3, 8'hFC, 8'd5, 8'd6));
    chk("t1_count", count, 1);
    idle();
    tick();
    chk("t1_pop_valid", out_valid, 0);
    chk("t1_pop_count", count, 0);

    // 2: streaming with out_ready high
    for (int c = 0; c < 8; c++) begin
      drive(c < 6 ? 2'b11 : 2'b00, 8'(c), 8'(c),
            (c >= 1 && c <= 6) ? 2'b11 : 2'b00, 8'(c-1), 8'(c-1));
      tick();
      if (c >= 1 && c <= 6) begin
        chk("t2_valid", out_valid, 1);
        chk("t2_row", out_row, row(8'(c-1), 8'(c-1), 8'(c-1), 8'(c-1)));
      end
    end
    chk("t2_ovf", overflow, 0);
    chk("t2_count", count, 0);

    // 3: overflow
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(c < 5 ? 2'b11 : 2'b00, 8'(10+c), 8'(10+c),
            c >= 1 ? 2'b11 : 2'b00, 8'(9+c), 8'(9+c));
      tick();
    end
    idle();
    chk("t3_count", count, 4);
    chk("t3_ovf", overflow, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_drain_valid", out_valid, 1);
      chk("t3_drain_row", out_row, row(8'(10+k), 8'(10+k), 8'(10+k), 8'(10+k)));
      tick();
    end
    chk("t3_empty", out_valid, 0);
    chk("t3_ovf_hold", overflow, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t3_ovf_clr", overflow, 0);

    // 4: alignment error
    drive(2'b11, 8'd1, 8'd2, 2'b00, 8'd0, 8'd0);
    tick();
    drive(2'b00, 8'd0, 8'd0, 2'b01, 8'd3, 8'd4);
    tick();
    idle();
    chk("t4_aerr", align_err, 1);
    chk("t4_count", count, 0);
    drive(2'b11, 8'd1, 8'd2, 2'b00, 8'd0, 8'd0);
    tick();
    drive(2'b00, 8'd0, 8'd0, 2'b01, 8'd3, 8'd4);
    clear_err = 1'b1;
    tick();
    idle();
    clear_err = 1'b0;
    chk("t4_aerr_wins", align_err, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t4_aerr_clr", align_err, 0);

    // 5: full with simultaneous push and pop
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      out_ready = (c == 5);
      drive(c < 5 ? 2'b11 : 2'b00, 8'(20+c), 8'(20+c),
            c >= 1 ? 2'b11 : 2'b00, 8'(19+c), 8'(19+c));
      tick();
      if (c == 4) chk("t5_full", count, 4);
    end
    idle();
    chk("t5_count", count, 4);
    chk("t5_ovf", overflow, 0);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk("t5_drain_row", out_row, row(8'(20+k), 8'(20+k), 8'(20+k), 8'(20+k)));
      tick();
    end
    chk("t5_empty", count, 0);

    // 6: reset mid-operation
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(c < 3 ? 2'b11 : 2'b00, 8'(30+c), 8'(30+c),
            c >= 1 ? 2'b11 : 2'b00, 8'(29+c), 8'(29+c));
      tick();
    end
    chk("t6_pre_count", count, 3);
    reset = 1'b1;
    drive(2'b11, 8'd33, 8'd33, 2'b00, 8'd0, 8'd0);
    tick();
    reset = 1'b0;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_aerr", align_err, 0);
    drive(2'b00, 8'd0, 8'd0, 2'b11, 8'd33, 8'd33);
    tick();
    idle();
    chk("t6_aerr", align_err, 1);
    chk("t6_count", count, 0);
    chk("t6_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
